icache_line_fill: RTL and testbench
===================================

Name: icache_line_fill

Overview:
- Refill sequencer between the icache miss logic and the icache AXI read master.
- On an icache miss it issues one line-aligned INCR burst request to the read master.
- It collects the returned 64-bit beats into a line buffer and presents the full line, with its error status, to the icache data/tag write port.
- Supports flush: an in-flight refill is drained and discarded, never written.

Parameters:
LINE_BEATS, 4, beats per cache line (power of 2, 2..16)
DATA_W, 64, beat width in bits; fixed to the AXI read data width
ADDR_W, 64, physical address width

Ports:
clk  in  1  core clock, same clock as the AXI master
rst  in  1  synchronous, active-high reset
miss_valid  in  1  miss request valid
miss_ready  out  1  fill unit can accept a miss
miss_paddr  in  ADDR_W  physical address of the missing fetch
flush  in  1  abort/discard current refill (fence.i, redirect)
start_burst  out  1  one-cycle pulse to the read master
burst_len  out  8  constant LINE_BEATS-1 (AXI ARLEN encoding)
read_address  out  ADDR_W  line-aligned burst start address
data_read  in  DATA_W  beat data from the read master
cache_beat  in  1  beat valid (RVALID & RREADY)
mem_done  in  1  last beat accepted
read_resp_error  in  1  SLVERR/DECERR on the current beat
line_valid  out  1  assembled line ready for the icache
line_ack  in  1  icache consumed the line
line_data  out  LINE_BEATS*DATA_W  beat k at bits [k*DATA_W +: DATA_W]
line_paddr  out  ADDR_W  line-aligned address of line_data
line_err  out  1  any beat errored or beat count wrong; icache must not mark the line valid

Behaviour:
- Reset values: all outputs 0; state IDLE. burst_len is the constant LINE_BEATS-1 at all times, including during reset.
- Sequential reset: rst mid-refill returns to IDLE and clears the beat count and sticky error. The read master is reset by its own ARESETN, the same system reset.
- OFF = log2(LINE_BEATS*DATA_W/8).
- read_address = {miss_paddr[ADDR_W-1:OFF], OFF'b0}, latched at miss acceptance and held until the next acceptance.
- States:
  - IDLE: miss_ready=1. On miss_valid&&!flush: latch address, clear beat_cnt and err, go REQ.
  - REQ: start_burst=1 for exactly this one cycle, then go FILL. If flush is high in REQ, the request is still issued and the state goes DRAIN.
  - FILL:
    - Each cache_beat writes data_read into slot beat_cnt, increments beat_cnt, and ORs read_resp_error into err.
    - Beats with beat_cnt==LINE_BEATS are dropped and set err.
    - On mem_done (same cycle as the last beat): go DONE; line_err = err | this beat's error | (final count != LINE_BEATS).
    - flush in FILL: go DRAIN; a beat arriving that same cycle is not stored.
    - flush and mem_done in the same cycle: go IDLE, no line_valid.
  - DRAIN: ignore beats; on mem_done go IDLE. line_valid never asserted.
  - DONE: line_valid=1; line_data, line_paddr and line_err held stable. On line_ack go IDLE. flush in DONE: drop the line, go IDLE.
- Latency:
  - miss accept (cycle 0) -> start_burst in cycle 1.
  - Last beat in cycle N -> line_valid in cycle N+1.
  - line_ack in cycle M -> miss_ready in cycle M+1.
- miss_ready is asserted only in IDLE; at most one outstanding burst.
- cache_beat or mem_done seen in IDLE or DONE is ignored.

Optional Feature:
ICACHE_FILL_FWD_EN:
- When defined, adds outputs fwd_valid (1) and fwd_data (DATA_W).
- In FILL, fwd_valid pulses for one cycle, in the same cycle as cache_beat, when beat_cnt equals miss_paddr[OFF-1:3]. fwd_data = data_read, so the fetch stage restarts before the line completes.
- Suppressed when the beat has read_resp_error, or when flush is high that cycle.
- When undefined, the ports are absent and there is no forwarding logic.

Decomposition:
- Shared icache package: state enum (IDLE, REQ, FILL, DRAIN, DONE), localparams OFF, BEAT_IDX_W, LINE_W, and the line-align function.
- One natural sub-module: icache_line_buffer, a LINE_BEATS x DATA_W register array with write-enable/index, clear, and flat line output. The FSM stays in icache_line_fill.

Test Plan:
- Normal fill:
  - Stimulus: miss_paddr=0x8000_1238, LINE_BEATS=4; 4 beats 0xA0..0xA3, mem_done on the 4th.
  - Required response: read_address=0x8000_1220; start_burst single pulse at cycle 1; line_valid next cycle; line_data={A3,A2,A1,A0}; line_err=0.
- Read error:
  - Stimulus: beat 2 with read_resp_error=1.
  - Required response: line_valid asserted with line_err=1; beats 0,1,3 are still stored.
- Flush mid-fill:
  - Stimulus: flush after beat 1, then remaining beats and mem_done.
  - Required response: no line_valid; miss_ready=1 the cycle after mem_done; a new miss 0x100 gives read_address=0x100.
- Short/long burst:
  - Stimulus: mem_done on the 3rd beat, or a 5th beat.
  - Required response: line_err=1 in both cases.
- Back-pressure:
  - Stimulus: line_ack held low 10 cycles; miss_valid high throughout.
  - Required response: line_data stable; miss_ready=0; no start_burst until the cycle after line_ack.
- Reset:
  - Stimulus: rst=1 during FILL after 2 beats, then a fresh miss.
  - Required response: all outputs 0; the fresh miss produces a full 4-beat line with no residue from the aborted fill.
- Forwarding (with ICACHE_FILL_FWD_EN):
  - Stimulus: miss 0x...18 (beat 3).
  - Required response: fwd_valid coincident with the 4th beat; fwd_data=0xA3.

Source files
------------

// File: rtl/icache_line_fill_pkg.sv
// Shared definitions for the icache refill sequencer: FSM states, line geometry, address alignment.
package icache_line_fill_pkg;

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, DONE} fill_state_t;

  localparam int LINE_BEATS_DEF = 4;
  localparam int DATA_W_DEF     = 64;
  localparam int ADDR_W_DEF     = 64;

  localparam int OFF        = $clog2(LINE_BEATS_DEF * DATA_W_DEF / 8);
  localparam int BEAT_IDX_W = $clog2(LINE_BEATS_DEF);
  localparam int LINE_W     = LINE_BEATS_DEF * DATA_W_DEF;

  function automatic int calc_off(input int line_beats, input int data_w);
    return $clog2(line_beats * data_w / 8);
  endfunction

  function automatic int calc_idx_w(input int line_beats);
    return $clog2(line_beats);
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] paddr, input int off);
    logic [63:0] mask;
    mask = {64{1'b1}} << off;
    return paddr & mask;
  endfunction

endpackage

// File: rtl/icache_line_fill_if.sv
// Miss, read-master and line-write handshakes of the refill sequencer.
// Forwarding signals exist only when ICACHE_FILL_FWD_EN is defined.
interface icache_line_fill_if
  import icache_line_fill_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
);
  logic                         miss_valid;
  logic                         miss_ready;
  logic [ADDR_W-1:0]            miss_paddr;
  logic                         flush;
  logic                         start_burst;
  logic [7:0]                   burst_len;
  logic [ADDR_W-1:0]            read_address;
  logic [DATA_W-1:0]            data_read;
  logic                         cache_beat;
  logic                         mem_done;
  logic                         read_resp_error;
  logic                         line_valid;
  logic                         line_ack;
  logic [LINE_BEATS*DATA_W-1:0] line_data;
  logic [ADDR_W-1:0]            line_paddr;
  logic                         line_err;
`ifdef ICACHE_FILL_FWD_EN
  logic                         fwd_valid;
  logic [DATA_W-1:0]            fwd_data;
`endif

  modport master (
    input  miss_valid, miss_paddr, flush, data_read, cache_beat, mem_done,
           read_resp_error, line_ack,
    output miss_ready, start_burst, burst_len, read_address, line_valid,
           line_data, line_paddr, line_err
`ifdef ICACHE_FILL_FWD_EN
    , output fwd_valid, fwd_data
`endif
  );

  modport slave (
    output miss_valid, miss_paddr, flush, data_read, cache_beat, mem_done,
           read_resp_error, line_ack,
    input  miss_ready, start_burst, burst_len, read_address, line_valid,
           line_data, line_paddr, line_err
`ifdef ICACHE_FILL_FWD_EN
    , input fwd_valid, fwd_data
`endif
  );

endinterface

// File: rtl/icache_line_buffer.sv
// Line assembly buffer: LINE_BEATS slots of DATA_W bits, indexed write, bulk clear, flat line view.
module icache_line_buffer #(
  parameter int LINE_BEATS = 4,
  parameter int DATA_W     = 64,
  parameter int IDX_W      = $clog2(LINE_BEATS)
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [DATA_W-1:0]            wdata,
  output logic [LINE_BEATS*DATA_W-1:0] line
);

  logic [DATA_W-1:0] slot [LINE_BEATS];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < LINE_BEATS; k++) slot[k] <= '0;
    end else if (we) begin
      slot[idx] <= wdata;
    end
  end

  for (genvar g = 0; g < LINE_BEATS; g++) begin : g_flat
    assign line[g*DATA_W +: DATA_W] = slot[g];
  end

endmodule

// File: rtl/icache_line_fill.sv
// Icache refill sequencer: one line-aligned burst per miss, beats assembled into a line with error status.
// Define ICACHE_FILL_FWD_EN to add critical-beat forwarding (fwd_valid/fwd_data).
module icache_line_fill
  import icache_line_fill_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  icache_line_fill_if.master bus
);

  localparam int LOFF  = calc_off(LINE_BEATS, DATA_W);
  localparam int IDX_W = calc_idx_w(LINE_BEATS);
  localparam int CNT_W = IDX_W + 1;
  localparam int LW    = LINE_BEATS * DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_BEATS);

  fill_state_t       state;
  logic [CNT_W-1:0]  beat_cnt;
  logic              err;
  logic [ADDR_W-1:0] line_addr;
  logic              miss_ready_r;
  logic              start_burst_r;
  logic              line_valid_r;
  logic              line_err_r;
  logic [LW-1:0]     line_flat;

  logic              accept;
  logic              beat_take;
  logic              beat_over;
  logic [CNT_W-1:0]  cnt_final;
  logic              err_final;
  logic              buf_clear;

  // beat_cnt saturates at LINE_BEATS; beats beyond that are dropped and flagged
  always_comb begin
    accept    = (state == IDLE) && miss_ready_r && bus.miss_valid && !bus.flush;
    beat_take = (state == FILL) && bus.cache_beat && !bus.flush && (beat_cnt != FULL_CNT);
    beat_over = (state == FILL) && bus.cache_beat && !bus.flush && (beat_cnt == FULL_CNT);
    cnt_final = beat_cnt + CNT_W'(beat_take);
    err_final = err | (bus.cache_beat & bus.read_resp_error) | beat_over | (cnt_final != FULL_CNT);
    buf_clear = rst | accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      err           <= 1'b0;
      line_addr     <= '0;
      miss_ready_r  <= 1'b0;
      start_burst_r <= 1'b0;
      line_valid_r  <= 1'b0;
      line_err_r    <= 1'b0;
    end else begin
      start_burst_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            line_addr     <= ADDR_W'(line_align(64'(bus.miss_paddr), LOFF));
            beat_cnt      <= '0;
            err           <= 1'b0;
            miss_ready_r  <= 1'b0;
            start_burst_r <= 1'b1;
            state         <= REQ;
          end else begin
            miss_ready_r <= 1'b1;
          end
        end
        // The request goes out even when flushed here; DRAIN soaks up its beats
        REQ: state <= bus.flush ? DRAIN : FILL;
        FILL: begin
          beat_cnt <= cnt_final;
          if (bus.cache_beat && !bus.flush) err <= err | bus.read_resp_error | beat_over;
          if (bus.flush) begin
            if (bus.mem_done) begin
              state        <= IDLE;
              miss_ready_r <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.mem_done) begin
            state        <= DONE;
            line_valid_r <= 1'b1;
            line_err_r   <= err_final;
          end
        end
        DRAIN: begin
          if (bus.mem_done) begin
            state        <= IDLE;
            miss_ready_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.flush || bus.line_ack) begin
            state        <= IDLE;
            line_valid_r <= 1'b0;
            line_err_r   <= 1'b0;
            miss_ready_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  icache_line_buffer #(
    .LINE_BEATS(LINE_BEATS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk  (clk),
    .clear(buf_clear),
    .we   (beat_take),
    .idx  (beat_cnt[IDX_W-1:0]),
    .wdata(bus.data_read),
    .line (line_flat)
  );

  assign bus.miss_ready   = miss_ready_r;
  assign bus.start_burst  = start_burst_r;
  assign bus.burst_len    = 8'(LINE_BEATS - 1);
  assign bus.read_address = line_addr;
  assign bus.line_paddr   = line_addr;
  assign bus.line_valid   = line_valid_r;
  assign bus.line_err     = line_err_r;
  assign bus.line_data    = line_flat;

`ifdef ICACHE_FILL_FWD_EN
  logic [IDX_W-1:0] crit_idx;

  // Beat index of the missing fetch within its line
  always_ff @(posedge clk) begin
    if (accept) crit_idx <= bus.miss_paddr[LOFF-1 -: IDX_W];
  end

  assign bus.fwd_valid = (state == FILL) && bus.cache_beat && !bus.flush &&
                         !bus.read_resp_error && (beat_cnt == {1'b0, crit_idx});
  assign bus.fwd_data  = bus.data_read;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: table of fill vectors plus flush, back-pressure and reset sequences.
module tb_icache_line_fill;
  import icache_line_fill_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  icache_line_fill_if bus ();

  icache_line_fill dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [63:0]       paddr;
    logic [63:0]       exp_addr;
    int                nbeats;
    int                err_beat;
    logic [63:0]       base;
    logic              exp_err;
    logic [LINE_W-1:0] exp_data;
    int                fwd_beat;
  } fill_vec_t;

  fill_vec_t vec [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic accept_miss(input logic [63:0] paddr, input logic [63:0] exp_addr);
    int n = 0;
    while (bus.miss_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("miss_ready_wait", bus.miss_ready, 1);
    bus.miss_paddr = paddr;
    bus.miss_valid = 1'b1;
    step();
    bus.miss_valid = 1'b0;
    check("start_burst_pulse", bus.start_burst, 1);
    check("read_address", bus.read_address, exp_addr);
    check("miss_ready_busy", bus.miss_ready, 0);
    step();
    check("start_burst_single", bus.start_burst, 0);
  endtask

  task automatic send_beats(input int n, input int err_beat, input logic [63:0] base,
                            input int done_beat, input int fwd_beat);
    for (int i = 0; i < n; i++) begin
      bus.data_read       = base + 64'(i);
      bus.cache_beat      = 1'b1;
      bus.read_resp_error = (i == err_beat);
      bus.mem_done        = (i == done_beat);
      #1;
`ifdef ICACHE_FILL_FWD_EN
      check("fwd_valid", bus.fwd_valid, (i == fwd_beat));
      if (i == fwd_beat) check("fwd_data", bus.fwd_data, base + 64'(i));
`else
      if (fwd_beat > 64) $display("fwd_beat %0d", fwd_beat);
`endif
      step();
    end
    bus.cache_beat      = 1'b0;
    bus.read_resp_error = 1'b0;
    bus.mem_done        = 1'b0;
  endtask

  task automatic check_line(input logic [LINE_W-1:0] exp_data, input logic exp_err,
                            input logic [63:0] exp_addr);
    check("line_valid", bus.line_valid, 1);
    check("line_data", bus.line_data, exp_data);
    check("line_err", bus.line_err, exp_err);
    check("line_paddr", bus.line_paddr, exp_addr);
  endtask

  task automatic ack_line();
    bus.line_ack = 1'b1;
    step();
    bus.line_ack = 1'b0;
    check("line_valid_after_ack", bus.line_valid, 0);
    check("miss_ready_after_ack", bus.miss_ready, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_miss_ready"}, bus.miss_ready, 0);
    check({tag, "_start_burst"}, bus.start_burst, 0);
    check({tag, "_line_valid"}, bus.line_valid, 0);
    check({tag, "_line_err"}, bus.line_err, 0);
    check({tag, "_line_data"}, bus.line_data, 0);
    check({tag, "_read_address"}, bus.read_address, 0);
    check({tag, "_line_paddr"}, bus.line_paddr, 0);
    check({tag, "_burst_len"}, bus.burst_len, 3);
  endtask

  initial begin
    vec[0] = '{64'h0000_0000_8000_1238, 64'h0000_0000_8000_1220, 4, -1, 64'hA0, 1'b0,
               {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 3};
    vec[1] = '{64'h40, 64'h40, 4, 2, 64'hB0, 1'b1,
               {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 0};
    vec[2] = '{64'h1F, 64'h0, 3, -1, 64'hC0, 1'b1,
               {64'h0, 64'hC2, 64'hC1, 64'hC0}, -1};
    vec[3] = '{64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DEE0, 5, -1, 64'hD0, 1'b1,
               {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 2};
    vec[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0, 4, 0, 64'hE0, 1'b1,
               {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 3};

    rst                 = 1'b1;
    bus.miss_valid      = 1'b0;
    bus.miss_paddr      = '0;
    bus.flush           = 1'b0;
    bus.data_read       = '0;
    bus.cache_beat      = 1'b0;
    bus.mem_done        = 1'b0;
    bus.read_resp_error = 1'b0;
    bus.line_ack        = 1'b0;
    step();
    step();
    check_zero_outputs("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      accept_miss(vec[v].paddr, vec[v].exp_addr);
      send_beats(vec[v].nbeats, vec[v].err_beat, vec[v].base, vec[v].nbeats - 1, vec[v].fwd_beat);
      check_line(vec[v].exp_data, vec[v].exp_err, vec[v].exp_addr);
      ack_line();
    end

    // Flush after beat 1: remaining beats drained, no line, then a fresh miss
    accept_miss(64'h8000_1238, 64'h8000_1220);
    send_beats(2, -1, 64'h10, -1, -1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_no_line", bus.line_valid, 0);
    send_beats(2, -1, 64'h12, 1, -1);
    check("flush_ready_after_done", bus.miss_ready, 1);
    check("flush_no_line_after_done", bus.line_valid, 0);
    accept_miss(64'h100, 64'h100);
    send_beats(4, -1, 64'h20, 3, 0);
    check_line({64'h23, 64'h22, 64'h21, 64'h20}, 1'b0, 64'h100);
    ack_line();

    // Back-pressure: line held while the next miss waits
    accept_miss(64'h8000_1238, 64'h8000_1220);
    send_beats(4, -1, 64'h30, 3, 3);
    check_line({64'h33, 64'h32, 64'h31, 64'h30}, 1'b0, 64'h8000_1220);
    bus.miss_paddr = 64'h200;
    bus.miss_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_line_data", bus.line_data, {64'h33, 64'h32, 64'h31, 64'h30});
      check("bp_miss_ready", bus.miss_ready, 0);
      check("bp_start_burst", bus.start_burst, 0);
    end
    bus.line_ack = 1'b1;
    step();
    bus.line_ack = 1'b0;
    check("bp_ready_after_ack", bus.miss_ready, 1);
    check("bp_no_burst_yet", bus.start_burst, 0);
    accept_miss(64'h200, 64'h200);
    send_beats(4, -1, 64'h40, 3, 0);
    check_line({64'h43, 64'h42, 64'h41, 64'h40}, 1'b0, 64'h200);
    ack_line();

    // Reset during FILL after two beats, one of them errored
    accept_miss(64'h300, 64'h300);
    send_beats(2, 1, 64'h50, -1, 0);
    rst = 1'b1;
    step();
    check_zero_outputs("midrst");
    rst = 1'b0;
    accept_miss(64'h8000_1238, 64'h8000_1220);
    send_beats(4, -1, 64'h60, 3, 3);
    check_line({64'h63, 64'h62, 64'h61, 64'h60}, 1'b0, 64'h8000_1220);
    ack_line();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
